// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_cmd_pkg
// Desc   : Shared encodings and helpers for the UART command controller.
// Rev    : 1.0  initial release
// ============================================================================
package uart_cmd_pkg;

  localparam int c_chk_w = 8;

  localparam logic [7:0] c_sync0 = 8'h55;
  localparam logic [7:0] c_sync1 = 8'hAA;

  typedef logic [2:0] state_t;

  localparam state_t c_st_hdr0   = 3'd0;
  localparam state_t c_st_hdr1   = 3'd1;
  localparam state_t c_st_addr   = 3'd2;
  localparam state_t c_st_len    = 3'd3;
  localparam state_t c_st_data   = 3'd4;
  localparam state_t c_st_chk    = 3'd5;
  localparam state_t c_st_commit = 3'd6;

  // Counter/index width that never collapses to zero bits.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_payload_buf.sv
`default_nettype none
// ============================================================================
// Module : cmd_payload_buf
// Desc   : Payload register file, synchronous write / combinational read.
// Rev    : 1.0  initial release
// ============================================================================
module cmd_payload_buf
  import uart_cmd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [7:0]       i_wr_data,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [7:0]       o_rd_data
);

  logic [7:0] r_mem [DEPTH];

  // Contents are only read after a full payload has been written, so no reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_cmd_ctrl
// Desc   : Parses checksummed config frames from the UART and commits them.
// Rev    : 1.0  initial release
// ============================================================================
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 40000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       rx_data_ready,
  output logic       reg_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);

  localparam int c_idx_w = idx_width(MAX_LEN);
  localparam int c_tmo_w = idx_width(TIMEOUT_CYCLES);

  localparam logic [8:0]         c_max_len  = 9'(MAX_LEN);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [7:0]           r_base;
  logic [7:0]           r_len;
  logic [c_chk_w-1:0]   r_acc;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_idx_w-1:0]   w_idx_p1;
  logic [c_idx_w-1:0]   w_rd_idx;
  logic [c_tmo_w-1:0]   r_tmo;

  logic                 w_accept;
  logic                 w_timed;
  logic                 w_tmo_hit;
  logic                 w_len_bad;
  logic                 w_chk_ok;
  logic                 w_idx_last;

  logic                 w_buf_we;
  logic [7:0]           w_rd_data;
  logic                 w_wr_load;
  logic                 w_ok_nxt;
  logic                 w_err_nxt;

  logic                 r_wr_en;
  logic [7:0]           r_wr_addr;
  logic [7:0]           r_wr_data;
  logic                 r_ok;
  logic                 r_err;

  assign rx_data_ready = (r_state != c_st_commit);
  assign busy          = (r_state != c_st_hdr0);
  assign reg_wr_en     = r_wr_en;
  assign reg_addr      = r_wr_addr;
  assign reg_wr_data   = r_wr_data;
  assign frame_ok      = r_ok;
  assign frame_err     = r_err;

  assign w_accept   = rx_data_valid & rx_data_ready;
  assign w_timed    = r_state inside {c_st_hdr1, c_st_addr, c_st_len, c_st_data, c_st_chk};
  // A byte arriving on the terminal count wins over the timeout.
  assign w_tmo_hit  = w_timed && !w_accept && (r_tmo == c_tmo_last);
  assign w_len_bad  = (rx_data == 8'd0) || ({1'b0, rx_data} > c_max_len);
  assign w_chk_ok   = (rx_data == r_acc);
  assign w_idx_p1   = r_idx + c_idx_w'(1);
  assign w_idx_last = (8'(r_idx) == (r_len - 8'd1));

  cmd_payload_buf #(
    .DEPTH (MAX_LEN),
    .IDX_W (c_idx_w)
  ) u_buf (
    .clk       (clk),
    .i_wr_en   (w_buf_we),
    .i_wr_idx  (r_idx),
    .i_wr_data (rx_data),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_hdr0;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_hdr0: begin
        if (w_accept && rx_data == c_sync0) w_next_state = c_st_hdr1;
      end
      c_st_hdr1: begin
        if (w_accept) begin
          if (rx_data == c_sync1)      w_next_state = c_st_addr;
          else if (rx_data != c_sync0) w_next_state = c_st_hdr0;
        end
      end
      c_st_addr: begin
        if (w_accept) w_next_state = c_st_len;
      end
      c_st_len: begin
        if (w_accept) w_next_state = w_len_bad ? c_st_hdr0 : c_st_data;
      end
      c_st_data: begin
        if (w_accept && w_idx_last) w_next_state = c_st_chk;
      end
      c_st_chk: begin
        if (w_accept) w_next_state = w_chk_ok ? c_st_commit : c_st_hdr0;
      end
      c_st_commit: begin
        if (w_idx_last) w_next_state = c_st_hdr0;
      end
      default: w_next_state = c_st_hdr0;
    endcase
    if (w_tmo_hit) w_next_state = c_st_hdr0;
  end

  // r_idx in COMMIT names the write currently on the output registers.
  always_comb begin
    w_buf_we  = 1'b0;
    w_wr_load = 1'b0;
    w_rd_idx  = '0;
    w_ok_nxt  = 1'b0;
    w_err_nxt = 1'b0;
    case (r_state)
      c_st_len: begin
        if (w_accept && w_len_bad) w_err_nxt = 1'b1;
      end
      c_st_data: begin
        w_buf_we = w_accept;
      end
      c_st_chk: begin
        if (w_accept) begin
          if (w_chk_ok) begin
            w_wr_load = 1'b1;
            w_ok_nxt  = (r_len == 8'd1);
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      c_st_commit: begin
        if (!w_idx_last) begin
          w_wr_load = 1'b1;
          w_rd_idx  = w_idx_p1;
          w_ok_nxt  = (8'(w_idx_p1) == (r_len - 8'd1));
        end
      end
      default: ;
    endcase
    if (w_tmo_hit && r_state != c_st_hdr1) w_err_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= '0;
      r_len  <= '0;
      r_acc  <= '0;
      r_idx  <= '0;
      r_tmo  <= '0;
    end else begin
      if (!w_timed || w_accept || (w_next_state != r_state)) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + c_tmo_w'(1);
      end
      case (r_state)
        c_st_addr: begin
          if (w_accept) begin
            r_base <= rx_data;
            r_acc  <= rx_data;
          end
        end
        c_st_len: begin
          if (w_accept) begin
            r_len <= rx_data;
            r_acc <= r_acc + rx_data;
            r_idx <= '0;
          end
        end
        c_st_data: begin
          if (w_accept) begin
            r_acc <= r_acc + rx_data;
            r_idx <= w_idx_p1;
          end
        end
        c_st_chk: begin
          if (w_accept) r_idx <= '0;
        end
        c_st_commit: begin
          if (!w_idx_last) r_idx <= w_idx_p1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_ok      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= w_wr_load;
      r_ok    <= w_ok_nxt;
      r_err   <= w_err_nxt;
      if (w_wr_load) begin
        r_wr_addr <= r_base + 8'(w_rd_idx);
        r_wr_data <= w_rd_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_cmd_ctrl
// Desc   : Directed and randomized frame bench with a frame-level reference.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_cmd_ctrl;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       reg_wr_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic       busy;

  uart_cmd_ctrl #(
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .reg_wr_en     (reg_wr_en),
    .reg_addr      (reg_addr),
    .reg_wr_data   (reg_wr_data),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed activity, sampled mid-cycle.
  logic [15:0] obs_wr[$];
  int          obs_wr_cyc[$];
  int          ok_cnt    = 0;
  int          err_cnt   = 0;
  int          ok_cyc    = -1;
  int          err_cyc   = -1;
  int          ok_wr_pos = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr_en) begin
        obs_wr.push_back({reg_addr, reg_wr_data});
        obs_wr_cyc.push_back(cyc);
      end
      if (frame_ok) begin
        ok_cnt++;
        ok_cyc    = cyc;
        ok_wr_pos = reg_wr_en ? obs_wr.size() : -1;
      end
      if (frame_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  logic [7:0]  tx_q[$];
  logic [7:0]  pay[$];
  logic [15:0] exp_wr[$];

  task automatic clear_obs();
    obs_wr.delete();
    obs_wr_cyc.delete();
    ok_cnt    = 0;
    err_cnt   = 0;
    ok_cyc    = -1;
    err_cyc   = -1;
    ok_wr_pos = -1;
  endtask

  task automatic rand_payload(input int len);
    pay.delete();
    repeat (len) pay.push_back(8'($urandom));
  endtask

  // Reference: checksum and expected write burst straight from the frame rules.
  task automatic build_frame(input logic [7:0] addr, input bit corrupt);
    int         sum;
    logic [7:0] chk;
    sum = int'(addr) + pay.size();
    foreach (pay[i]) sum += int'(pay[i]);
    chk = 8'(sum % 256);
    if (corrupt) chk = chk ^ 8'(1 << $urandom_range(0, 7));
    tx_q.push_back(8'h55);
    tx_q.push_back(8'hAA);
    tx_q.push_back(addr);
    tx_q.push_back(8'(pay.size()));
    foreach (pay[i]) tx_q.push_back(pay[i]);
    tx_q.push_back(chk);
    exp_wr.delete();
    if (!corrupt) begin
      foreach (pay[i]) exp_wr.push_back({8'((int'(addr) + i) % 256), pay[i]});
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int n = 0;
    rx_data       = b;
    rx_data_valid = 1'b1;
    while (!rx_data_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_wait", 32'(rx_data_ready), 32'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    rx_data_valid = 1'b0;
  endtask

  task automatic send_all(output int last_acc);
    last_acc = -1;
    foreach (tx_q[i]) send_byte(tx_q[i], last_acc);
    tx_q.delete();
  endtask

  task automatic expect_result(input bit good, input int last_acc, input string tag, input bit idle_after);
    for (int i = 0; i < 80 && (ok_cnt + err_cnt) == 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    if (good) begin
      check({tag, "_ok_cnt"}, 32'(ok_cnt), 32'd1);
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
      check({tag, "_n_wr"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
      foreach (exp_wr[i]) begin
        if (i < obs_wr.size()) check({tag, "_wr"}, 32'(obs_wr[i]), 32'(exp_wr[i]));
      end
      if (obs_wr_cyc.size() > 0) begin
        check({tag, "_first_wr_cyc"}, 32'(obs_wr_cyc[0]), 32'(last_acc + 1));
        check({tag, "_burst_span"}, 32'(obs_wr_cyc[$] - obs_wr_cyc[0]), 32'(exp_wr.size() - 1));
      end
      check({tag, "_ok_on_last_wr"}, 32'(ok_wr_pos), 32'(exp_wr.size()));
    end else begin
      check({tag, "_ok_cnt"}, 32'(ok_cnt), 32'd0);
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'd1);
      check({tag, "_n_wr"}, 32'(obs_wr.size()), 32'd0);
      check({tag, "_err_cyc"}, 32'(err_cyc), 32'(last_acc + 1));
    end
    if (idle_after) check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(reg_wr_en), 32'd0);
    check({tag, "_ok"}, 32'(frame_ok), 32'd0);
    check({tag, "_err"}, 32'(frame_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_addr"}, 32'(reg_addr), 32'd0);
    check({tag, "_wdata"}, 32'(reg_wr_data), 32'd0);
    check({tag, "_ready"}, 32'(rx_data_ready), 32'd1);
  endtask

  initial begin
    int a;
    int a2;
    rst_n         = 1'b0;
    rx_data       = 8'h00;
    rx_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reference frame from the datasheet example.
    clear_obs();
    tx_q   = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
    exp_wr = '{16'h1001, 16'h1102, 16'h1203};
    send_all(a);
    expect_result(1'b1, a, "ref", 1'b1);

    clear_obs();
    tx_q = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h18};
    send_all(a);
    expect_result(1'b0, a, "badchk", 1'b1);

    clear_obs();
    rand_payload(5);
    build_frame(8'h20, 1'b0);
    send_all(a);
    expect_result(1'b1, a, "after_bad", 1'b1);

    clear_obs();
    tx_q = '{8'h55, 8'hAA, 8'h33, 8'h00};
    send_all(a);
    expect_result(1'b0, a, "len0", 1'b1);

    clear_obs();
    tx_q = '{8'h55, 8'hAA, 8'h33, 8'(MAX_LEN + 1)};
    send_all(a);
    expect_result(1'b0, a, "len_over", 1'b1);

    clear_obs();
    rand_payload(MAX_LEN);
    build_frame(8'h80, 1'b0);
    send_all(a);
    expect_result(1'b1, a, "len_max", 1'b1);

    clear_obs();
    rand_payload(3);
    build_frame(8'hFE, 1'b0);
    send_all(a);
    expect_result(1'b1, a, "addr_wrap", 1'b1);

    // Stall after two payload bytes.
    clear_obs();
    tx_q = '{8'h55, 8'hAA, 8'h05, 8'h04, 8'hA1, 8'hA2};
    send_all(a);
    for (int i = 0; i < TIMEOUT + 30 && err_cnt == 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("stall_err_cnt", 32'(err_cnt), 32'd1);
    check("stall_err_cyc", 32'(err_cyc), 32'(a + TIMEOUT + 1));
    check("stall_n_wr", 32'(obs_wr.size()), 32'd0);
    check("stall_busy", 32'(busy), 32'd0);

    // Lone sync byte times out silently.
    clear_obs();
    tx_q = '{8'h55};
    send_all(a);
    repeat (TIMEOUT + 10) @(posedge clk);
    #1;
    check("hdr1_tmo_err", 32'(err_cnt), 32'd0);
    check("hdr1_tmo_busy", 32'(busy), 32'd0);

    clear_obs();
    tx_q = '{8'h12, 8'h55, 8'h33, 8'h55, 8'h55};
    rand_payload(4);
    build_frame(8'h60, 1'b0);
    send_all(a);
    expect_result(1'b1, a, "resync", 1'b1);
    check("resync_err", 32'(err_cnt), 32'd0);

    // Next frame's first byte offered while the burst is in progress.
    clear_obs();
    rand_payload(4);
    build_frame(8'h40, 1'b0);
    send_all(a);
    rx_data       = 8'h55;
    rx_data_valid = 1'b1;
    #1;
    check("pend_ready_low", 32'(rx_data_ready), 32'd0);
    check("pend_busy", 32'(busy), 32'd1);
    send_byte(8'h55, a2);
    check("pend_accept_cyc", 32'(a2), 32'(ok_cyc + 1));
    expect_result(1'b1, a, "pend", 1'b0);
    clear_obs();
    rand_payload(2);
    build_frame(8'h41, 1'b0);
    void'(tx_q.pop_front());
    send_all(a);
    expect_result(1'b1, a, "pend_next", 1'b1);

    // Reset mid-payload.
    clear_obs();
    tx_q = '{8'h55, 8'hAA, 8'h30, 8'h05, 8'hD0, 8'hD1};
    send_all(a);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("rst_data");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_obs();
    rand_payload(3);
    build_frame(8'h31, 1'b0);
    send_all(a);
    expect_result(1'b1, a, "rst_data_next", 1'b1);

    // Reset three writes into a burst.
    clear_obs();
    rand_payload(MAX_LEN);
    build_frame(8'h90, 1'b0);
    send_all(a);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_commit");
    check("rst_commit_n_wr", 32'(obs_wr.size()), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_commit_ok", 32'(ok_cnt), 32'd0);
    check("rst_commit_err", 32'(err_cnt), 32'd0);
    check("rst_commit_n_wr_after", 32'(obs_wr.size()), 32'd3);
    clear_obs();
    rand_payload(6);
    build_frame(8'h91, 1'b0);
    send_all(a);
    expect_result(1'b1, a, "rst_commit_next", 1'b1);

    // Randomized frames, a quarter with a corrupted checksum.
    for (int f = 0; f < 12; f++) begin
      bit bad;
      bad = ($urandom_range(0, 3) == 0);
      clear_obs();
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      rand_payload($urandom_range(1, MAX_LEN));
      build_frame(8'($urandom), bad);
      send_all(a);
      expect_result(!bad, a, "rand", 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Frame-level command controller placed directly downstream of the lidar's UART receiver. It sequences byte consumption through the receiver's valid/ready handshake and parses framed configuration commands. Each command payload is buffered and checksum-verified before any side effect. Only a verified frame is committed as a burst of single-cycle register writes into the lidar configuration register bank.

## Interface
Parameters:
- MAX_LEN, 16: maximum payload bytes per frame (1..255); sets payload buffer depth.
- TIMEOUT_CYCLES, 40000: inter-byte timeout in clk cycles (1 ms at 40 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  8  byte from UART receiver.
- rx_data_valid  in  1  byte available; held until accepted.
- rx_data_ready  out  1  controller can accept a byte.
- reg_wr_en  out  1  single-cycle register write strobe.
- reg_addr  out  8  register write address.
- reg_wr_data  out  8  register write data.
- frame_ok  out  1  one-cycle pulse: frame committed.
- frame_err  out  1  one-cycle pulse: frame dropped (length, checksum or timeout).
- busy  out  1  high whenever state is not HDR0.

## Operation
- Byte accept: rx_data_valid && rx_data_ready on a rising clk edge.
- rx_data_ready is combinational: 1 in every state except COMMIT.
- Frame format:
  - 0x55, 0xAA, ADDR, LEN, DATA[0..LEN-1], CHK.
  - CHK = (ADDR + LEN + ΣDATA) mod 256, using an 8-bit wrapping accumulator.
- States and transitions (each advance is on an accepted byte):
  - HDR0:
    - 0x55 → HDR1; any other byte stays in HDR0.
  - HDR1:
    - 0xAA → ADDR.
    - 0x55 → stay in HDR1.
    - Any other byte → HDR0, with no frame_err.
  - ADDR: latch the start address; accumulator ← ADDR → LEN.
  - LEN:
    - LEN == 0 or LEN > MAX_LEN → frame_err, HDR0.
    - Otherwise latch LEN, clear idx → DATA.
  - DATA: buf[idx] ← byte; accumulate; idx++. The byte accepted with idx == LEN-1 → CHK.
  - CHK:
    - byte == accumulator → COMMIT, idx cleared.
    - Mismatch → frame_err, HDR0.
  - COMMIT: one write per cycle for LEN cycles.
    - reg_addr = ADDR + idx, 8-bit wrap (0xFF + 1 → 0x00).
    - reg_wr_data = buf[idx].
    - On the last write, frame_ok pulses in the same cycle → HDR0.
- Timeout: states HDR1 through CHK only.
  - A counter clears on every accepted byte and on state entry.
  - On reaching TIMEOUT_CYCLES-1: frame_err if the state is ADDR or later (silent return from HDR1), then HDR0.
- No register write ever occurs for a dropped frame.
- A partially received frame leaves the register bank untouched.

## Timing
- Reset values:
  - State HDR0; reg_wr_en, frame_ok, frame_err, busy = 0.
  - reg_addr, reg_wr_data = 0x00; rx_data_ready = 1.
  - Buffer contents are don't-care.
- First reg_wr_en is asserted in the cycle after the CHK byte is accepted. Writes are back-to-back, LEN cycles total.
- frame_err is asserted in the cycle after the offending byte is accepted, or after the timeout terminal count.
- In COMMIT, rx_data_valid is ignored. The receiver holds its byte; it is accepted in HDR0 on the first cycle after COMMIT.
- Simultaneous byte accept and timeout terminal count: the byte wins and the counter clears.
- rst_n assertion mid-COMMIT: writes stop immediately and frame_ok is not pulsed. The remaining writes are lost, which is acceptable.
- reg_wr_en, reg_addr, reg_wr_data, frame_ok and frame_err are registered outputs.

## Structure
- Shared package uart_cmd_pkg holds:
  - State encoding for HDR0, HDR1, ADDR, LEN, DATA, CHK, COMMIT.
  - Header constants 0x55/0xAA.
  - Checksum width (8).
- Sub-module cmd_payload_buf: MAX_LEN×8 register file.
  - Synchronous write port, combinational read port.
  - Index width $clog2(MAX_LEN).
- FSM, accumulator, idx and timeout counter live in uart_cmd_ctrl.

## Test plan
- Valid frame 55 AA 10 03 01 02 03 CHK=0x19:
  - Three consecutive writes (0x10,0x01), (0x11,0x02), (0x12,0x03).
  - frame_ok on the third write; no frame_err.
- Same frame with CHK=0x18: frame_err once, zero writes; the next valid frame commits normally.
- LEN=0 and LEN=MAX_LEN+1: frame_err after the LEN byte, return to HDR0; LEN=MAX_LEN frame commits all 16 bytes.
- ADDR=0xFE, LEN=3: writes go to 0xFE, 0xFF, 0x00.
- Stall and resync cases:
  - Stall after 2 DATA bytes for TIMEOUT_CYCLES cycles: frame_err, no writes.
  - Noise 55 55 AA … resyncs to a valid frame.
- Byte presented during COMMIT stays pending (rx_data_ready=0) and is accepted the cycle after frame_ok.
- rst_n pulsed mid-DATA or mid-COMMIT: all outputs at their reset values; the following frame commits correctly.
